spi_frame_ctrl: RTL and testbench
=================================

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 10, number of writable command bytes per frame (indices 0..9).
REQ-002 SHALL have parameter WD_TIMEOUT, default 400000, watchdog limit in clk cycles (10 ms at 40 MHz); 0 disables the watchdog.
REQ-003 SHALL have port clk  in  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port nRESET  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port frame_start  in  1  one-cycle pulse at SSEL falling edge (already synchronised).
REQ-006 SHALL have port frame_end  in  1  one-cycle pulse at SSEL rising edge.
REQ-007 SHALL have port byte_valid  in  1  one-cycle pulse, received byte ready.
REQ-008 SHALL have port byte_index  in  6  byte position within frame.
REQ-009 SHALL have port byte_data  in  8  received byte.
REQ-010 SHALL have ports pwm0..pwm3  out  16 each  committed PWM words (bytes 2n = low, 2n+1 = high).
REQ-011 SHALL have port dout_reg  out  10  committed digital outputs (byte 8 -> [7:0], byte 9[1:0] -> [9:8]).
REQ-012 SHALL have port zpol  out  1  committed Z polarity (byte 9 bit 7).
REQ-013 SHALL have port snap  out  1  one-cycle pulse requesting quadrature-counter snapshot.
REQ-014 SHALL have ports wd_tripped  out  1, frame_err  out  1, frame_count  out  16  status.

Function
REQ-015 SHALL implement states IDLE, RECV, COMMIT.
REQ-016 IDLE + frame_start SHALL go to RECV, clear the 10-bit received mask and pulse snap in the same cycle the state becomes RECV.
REQ-017 In RECV, byte_valid with byte_index < FRAME_BYTES SHALL write byte_data to shadow[byte_index] and set mask[byte_index]; indices >= FRAME_BYTES SHALL be ignored.
REQ-018 In RECV, frame_end with a full mask SHALL go to COMMIT; with an incomplete mask it SHALL set frame_err, discard the shadow and go to IDLE.
REQ-019 byte_valid and frame_end in the same cycle SHALL write the byte first and evaluate the mask including it.
REQ-020 frame_start in RECV SHALL restart reception (clear mask, pulse snap), set frame_err and stay in RECV.
REQ-021 COMMIT SHALL last one cycle: copy all shadow bytes to the outputs atomically, increment frame_count (wrapping 0xFFFF -> 0), clear frame_err, wd_tripped and the watchdog counter, then go to IDLE.
REQ-022 Committed outputs SHALL be visible 2 cycles after the frame_end cycle; no output SHALL ever show a mix of old and new frame bytes.
REQ-023 Outside COMMIT, the watchdog counter SHALL increment every cycle and saturate at WD_TIMEOUT.
REQ-024 When the counter reaches WD_TIMEOUT, wd_tripped SHALL be set and pwm0..pwm3 SHALL be cleared to 0 the next cycle; dout_reg and zpol SHALL hold.
REQ-025 A commit in the same cycle as the trip condition SHALL win: outputs get the new frame and wd_tripped stays 0.
REQ-026 frame_start, frame_end and byte_valid in IDLE (other than frame_start) SHALL be ignored.

Reset
REQ-027 nRESET low SHALL force state IDLE, mask 0, all shadow bytes 0, pwm0..3 0, dout_reg 0x000, zpol 0, snap 0, frame_err 0, frame_count 0, watchdog counter 0, and wd_tripped 0.
REQ-028 Reset during RECV or COMMIT SHALL abort the frame with no partial commit.

Structure
REQ-029 Shared package pluto_spi_pkg SHALL hold the state enum, FRAME_BYTES, and the byte-map constants (PWM/DOUT/CFG byte indices, ZPOL bit 7).
REQ-030 Watchdog SHALL be a sub-module spi_wdog (counter, saturate, trip, clear input).

Verification
REQ-031 Full frame of bytes 0x01..0x0A then frame_end -> pwm0=0x0201, pwm1=0x0403, pwm2=0x0605, pwm3=0x0807, dout_reg=0x209, zpol=0, frame_count=1, 2 cycles after frame_end.
REQ-032 Frame of only bytes 0..7 then frame_end -> frame_err=1, outputs unchanged, frame_count unchanged.
REQ-033 WD_TIMEOUT=100 with no frames -> wd_tripped=1 and pwm0..3=0 at cycle 101 after reset release; a good frame then clears wd_tripped.
REQ-034 Byte 9=0x80 arriving in the same cycle as frame_end -> commit occurs and zpol=1.
REQ-035 nRESET pulsed low after byte 5 of a frame -> all outputs 0, state IDLE, and a later frame_end causes no commit.
REQ-036 frame_start twice within one frame -> two snap pulses, frame_err=1, and a complete second frame still commits.

Source files
------------

// File: rtl/pluto_spi_pkg.sv
// Shared types and byte-map constants for the SPI command-frame controller.
package pluto_spi_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCommit
  } frame_state_e;

  // Writable command bytes per frame
  localparam int unsigned FRAME_BYTES = 10;

  // Width of the received-byte mask (one bit per byte slot in the map below)
  localparam int unsigned MaskBits = 10;

  // Byte map: PWM words occupy bytes 0..7, low byte first
  localparam int unsigned NumPwm      = 4;
  localparam int unsigned PwmByteBase = 0;
  // Digital outputs [7:0]
  localparam int unsigned DoutByte    = 8;
  // Config byte: [1:0] -> dout[9:8], [7] -> Z polarity
  localparam int unsigned CfgByte     = 9;
  localparam int unsigned ZpolBit     = 7;

  function automatic int unsigned pwm_lo_byte(input int unsigned n);
    return PwmByteBase + 2 * n;
  endfunction

  function automatic int unsigned pwm_hi_byte(input int unsigned n);
    return PwmByteBase + 2 * n + 1;
  endfunction

endpackage

// File: rtl/spi_wdog.sv
// Link watchdog: counts idle cycles between commits, saturates at the limit
// and latches a trip flag. A limit of 0 disables it.
module spi_wdog #(
  parameter int unsigned WD_TIMEOUT = 400000
) (
  input  logic clk_i,
  input  logic rst_ni,     // synchronous, active-low
  input  logic clear_i,    // commit cycle: restart the count and drop the trip
  output logic tripped_o,
  output logic trip_now_o  // trip condition this cycle, already losing to clear_i
);

  logic [31:0] cnt_q, cnt_d;
  logic        tripped_q, tripped_d;
  logic        at_limit;

  assign at_limit   = (WD_TIMEOUT != 0) && (cnt_q == WD_TIMEOUT);
  assign trip_now_o = at_limit && !clear_i;
  assign tripped_o  = tripped_q;

  // Next-state: saturating counter and sticky trip flag
  always_comb begin
    cnt_d     = cnt_q;
    tripped_d = tripped_q;
    if (clear_i) begin
      cnt_d     = '0;
      tripped_d = 1'b0;
    end else begin
      if (cnt_q < WD_TIMEOUT) cnt_d = cnt_q + 32'd1;
      if (at_limit) tripped_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      tripped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tripped_q <= tripped_d;
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI command-frame controller: collects bytes into a shadow buffer and
// commits them to the output registers only when every byte has arrived.
module spi_frame_ctrl #(
  parameter int unsigned FRAME_BYTES = pluto_spi_pkg::FRAME_BYTES,
  parameter int unsigned WD_TIMEOUT  = 400000
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        byte_valid,
  input  logic [5:0]  byte_index,
  input  logic [7:0]  byte_data,
  output logic [15:0] pwm0,
  output logic [15:0] pwm1,
  output logic [15:0] pwm2,
  output logic [15:0] pwm3,
  output logic [9:0]  dout_reg,
  output logic        zpol,
  output logic        snap,
  output logic        wd_tripped,
  output logic        frame_err,
  output logic [15:0] frame_count
);
  import pluto_spi_pkg::*;

  // Slots actually tracked; indices at or above this are dropped
  localparam int unsigned UsedBytes = (FRAME_BYTES < MaskBits) ? FRAME_BYTES : MaskBits;
  localparam logic [MaskBits-1:0] FullMask = {MaskBits{1'b1}} >> (MaskBits - UsedBytes);

  frame_state_e          state_q, state_d;
  logic [MaskBits-1:0]   mask_q, mask_d;
  logic [7:0]            shadow_q [MaskBits];
  logic [7:0]            shadow_d [MaskBits];
  logic [15:0]           pwm_q [NumPwm];
  logic [15:0]           pwm_d [NumPwm];
  logic [9:0]            dout_q, dout_d;
  logic                  zpol_q, zpol_d;
  logic                  snap_q, snap_d;
  logic                  frame_err_q, frame_err_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic                  commit;
  logic                  byte_hit;
  logic [3:0]            slot;
  logic                  wd_trip_now;

  assign commit   = (state_q == StCommit);
  assign byte_hit = byte_valid && (byte_index < 6'(UsedBytes));
  assign slot     = byte_index[3:0];

  spi_wdog #(
    .WD_TIMEOUT (WD_TIMEOUT)
  ) u_wdog (
    .clk_i      (clk),
    .rst_ni     (nRESET),
    .clear_i    (commit),
    .tripped_o  (wd_tripped),
    .trip_now_o (wd_trip_now)
  );

  // Frame FSM: reception into the shadow buffer and completeness check
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    shadow_d    = shadow_q;
    snap_d      = 1'b0;
    frame_err_d = frame_err_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StRecv;
          mask_d  = '0;
          snap_d  = 1'b1;
        end
      end
      StRecv: begin
        if (frame_start) begin
          // Restart: earlier bytes of this frame no longer count
          mask_d      = '0;
          snap_d      = 1'b1;
          frame_err_d = 1'b1;
          if (byte_hit) begin
            shadow_d[slot] = byte_data;
            mask_d[slot]   = 1'b1;
          end
        end else begin
          // Byte lands before frame_end is judged, so a last byte on the end cycle counts
          if (byte_hit) begin
            shadow_d[slot] = byte_data;
            mask_d[slot]   = 1'b1;
          end
          if (frame_end) begin
            if ((mask_d & FullMask) == FullMask) begin
              state_d = StCommit;
            end else begin
              frame_err_d = 1'b1;
              mask_d      = '0;
              state_d     = StIdle;
            end
          end
        end
      end
      StCommit: begin
        state_d     = StIdle;
        mask_d      = '0;
        frame_err_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output registers: atomic load on commit, PWM forced off on watchdog trip
  always_comb begin
    pwm_d         = pwm_q;
    dout_d        = dout_q;
    zpol_d        = zpol_q;
    frame_count_d = frame_count_q;
    if (commit) begin
      for (int unsigned n = 0; n < NumPwm; n++) begin
        pwm_d[n] = {shadow_q[pwm_hi_byte(n)], shadow_q[pwm_lo_byte(n)]};
      end
      dout_d        = {shadow_q[CfgByte][1:0], shadow_q[DoutByte]};
      zpol_d        = shadow_q[CfgByte][ZpolBit];
      frame_count_d = frame_count_q + 16'd1;
    end else if (wd_trip_now) begin
      for (int unsigned n = 0; n < NumPwm; n++) pwm_d[n] = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      for (int unsigned i = 0; i < MaskBits; i++) shadow_q[i] <= '0;
      for (int unsigned n = 0; n < NumPwm; n++) pwm_q[n] <= '0;
      dout_q        <= '0;
      zpol_q        <= 1'b0;
      snap_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      pwm_q         <= pwm_d;
      dout_q        <= dout_d;
      zpol_q        <= zpol_d;
      snap_q        <= snap_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pwm0        = pwm_q[0];
  assign pwm1        = pwm_q[1];
  assign pwm2        = pwm_q[2];
  assign pwm3        = pwm_q[3];
  assign dout_reg    = dout_q;
  assign zpol        = zpol_q;
  assign snap        = snap_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: one instance with the default watchdog
// and one with a 100-cycle watchdog, sharing all inputs.
module tb_spi_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRESET, frame_start, frame_end, byte_valid;
  logic [5:0] byte_index;
  logic [7:0] byte_data;

  logic [15:0] pwm0, pwm1, pwm2, pwm3, frame_count;
  logic [9:0]  dout_reg;
  logic        zpol, snap, wd_tripped, frame_err;

  logic [15:0] pwm0_w, pwm1_w, pwm2_w, pwm3_w, frame_count_w;
  logic [9:0]  dout_reg_w;
  logic        zpol_w, snap_w, wd_tripped_w, frame_err_w;

  spi_frame_ctrl dut (
    .clk         (clk),
    .nRESET      (nRESET),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_valid  (byte_valid),
    .byte_index  (byte_index),
    .byte_data   (byte_data),
    .pwm0        (pwm0),
    .pwm1        (pwm1),
    .pwm2        (pwm2),
    .pwm3        (pwm3),
    .dout_reg    (dout_reg),
    .zpol        (zpol),
    .snap        (snap),
    .wd_tripped  (wd_tripped),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  spi_frame_ctrl #(
    .WD_TIMEOUT (100)
  ) dut_wd (
    .clk         (clk),
    .nRESET      (nRESET),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_valid  (byte_valid),
    .byte_index  (byte_index),
    .byte_data   (byte_data),
    .pwm0        (pwm0_w),
    .pwm1        (pwm1_w),
    .pwm2        (pwm2_w),
    .pwm3        (pwm3_w),
    .dout_reg    (dout_reg_w),
    .zpol        (zpol_w),
    .snap        (snap_w),
    .wd_tripped  (wd_tripped_w),
    .frame_err   (frame_err_w),
    .frame_count (frame_count_w)
  );

  // {pwm3, pwm2, pwm1, pwm0, dout_reg, zpol}
  logic [74:0] outs, outs_w;
  // {snap, wd_tripped, frame_err, frame_count}
  logic [18:0] stat, stat_w;
  assign outs   = {pwm3, pwm2, pwm1, pwm0, dout_reg, zpol};
  assign outs_w = {pwm3_w, pwm2_w, pwm1_w, pwm0_w, dout_reg_w, zpol_w};
  assign stat   = {snap, wd_tripped, frame_err, frame_count};
  assign stat_w = {snap_w, wd_tripped_w, frame_err_w, frame_count_w};

  // Hand-computed committed images
  localparam logic [74:0] Exp01 = {64'h0807_0605_0403_0201, 10'h209, 1'b0};
  localparam logic [74:0] Exp30 = {64'h3736_3534_3332_3130, 10'h138, 1'b0};
  localparam logic [74:0] Exp11 = {64'h1817_1615_1413_1211, 10'h019, 1'b1};
  localparam logic [74:0] Exp40 = {64'h4746_4544_4342_4140, 10'h148, 1'b0};
  localparam logic [74:0] Exp60 = {64'h6766_6564_6362_6160, 10'h168, 1'b0};
  localparam logic [74:0] ExpTrip01 = {64'h0, 10'h209, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  // Drive after the falling edge, let one rising edge sample, return at the next falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [5:0] idx, input logic [7:0] data);
    byte_valid = 1'b1;
    byte_index = idx;
    byte_data  = data;
    cyc();
    byte_valid = 1'b0;
  endtask

  // Bytes first..last carry base+index
  task automatic send_bytes(input logic [7:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(6'(i), base + 8'(i));
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    cyc();
    cyc();
    n_vec++;
    if (outs !== 75'd0) begin
      n_err++; $display("FAIL reset_outs got %h want 0", outs);
    end
    n_vec++;
    if (stat !== 19'd0) begin
      n_err++; $display("FAIL reset_status got %h want 0", stat);
    end
    n_vec++;
    if ({outs_w, stat_w} !== 94'd0) begin
      n_err++; $display("FAIL reset_wd_inst got %h want 0", {outs_w, stat_w});
    end
    nRESET = 1'b1;
  endtask

  task automatic test_full_frame();
    pulse_start();
    n_vec++;
    if (snap !== 1'b1) begin
      n_err++; $display("FAIL full_snap got %b want 1", snap);
    end
    send_bytes(8'h01, 0, 9);
    n_vec++;
    if (snap !== 1'b0) begin
      n_err++; $display("FAIL full_snap_low got %b want 0", snap);
    end
    pulse_end();
    n_vec++;
    if (outs !== 75'd0) begin
      n_err++; $display("FAIL full_early got %h want 0", outs);
    end
    cyc();
    n_vec++;
    if (outs !== Exp01) begin
      n_err++; $display("FAIL full_outs got %h want %h", outs, Exp01);
    end
    n_vec++;
    if ({frame_err, frame_count} !== {1'b0, 16'd1}) begin
      n_err++; $display("FAIL full_count got %h want %h", {frame_err, frame_count}, {1'b0, 16'd1});
    end
  endtask

  task automatic test_short_frame();
    pulse_start();
    send_bytes(8'hA0, 0, 7);
    pulse_end();
    cyc();
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_err++; $display("FAIL short_err got %b want 1", frame_err);
    end
    n_vec++;
    if ({outs, frame_count} !== {Exp01, 16'd1}) begin
      n_err++; $display("FAIL short_hold got %h want %h", {outs, frame_count}, {Exp01, 16'd1});
    end
  endtask

  task automatic test_out_of_range();
    // Index 10 must not fill the slot that byte 9 would
    pulse_start();
    send_bytes(8'h30, 0, 8);
    send_byte(6'd10, 8'hFF);
    send_byte(6'd63, 8'hEE);
    pulse_end();
    cyc();
    n_vec++;
    if ({frame_err, frame_count, outs} !== {1'b1, 16'd1, Exp01}) begin
      n_err++;
      $display("FAIL oor_incomplete got %h want %h", {frame_err, frame_count, outs},
               {1'b1, 16'd1, Exp01});
    end
    pulse_start();
    send_byte(6'd10, 8'hFF);
    send_bytes(8'h30, 0, 9);
    send_byte(6'd12, 8'hEE);
    pulse_end();
    cyc();
    n_vec++;
    if ({frame_err, frame_count, outs} !== {1'b0, 16'd2, Exp30}) begin
      n_err++;
      $display("FAIL oor_commit got %h want %h", {frame_err, frame_count, outs},
               {1'b0, 16'd2, Exp30});
    end
  endtask

  task automatic test_same_cycle_end();
    pulse_start();
    send_bytes(8'h11, 0, 8);
    byte_valid = 1'b1;
    byte_index = 6'd9;
    byte_data  = 8'h80;
    frame_end  = 1'b1;
    cyc();
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    cyc();
    n_vec++;
    if ({outs, frame_count} !== {Exp11, 16'd3}) begin
      n_err++; $display("FAIL same_cycle got %h want %h", {outs, frame_count}, {Exp11, 16'd3});
    end
  endtask

  task automatic test_double_start();
    pulse_start();
    n_vec++;
    if ({snap, frame_err} !== 2'b10) begin
      n_err++; $display("FAIL dbl_first got %b want 10", {snap, frame_err});
    end
    send_bytes(8'h55, 0, 4);
    pulse_start();
    n_vec++;
    if ({snap, frame_err} !== 2'b11) begin
      n_err++; $display("FAIL dbl_second got %b want 11", {snap, frame_err});
    end
    send_bytes(8'h40, 0, 9);
    pulse_end();
    cyc();
    n_vec++;
    if ({frame_err, frame_count, outs} !== {1'b0, 16'd4, Exp40}) begin
      n_err++;
      $display("FAIL dbl_commit got %h want %h", {frame_err, frame_count, outs},
               {1'b0, 16'd4, Exp40});
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_bytes(8'h60, 0, 9);
    pulse_end();
    cyc();
    n_vec++;
    if ({outs, frame_count} !== {Exp60, 16'd5}) begin
      n_err++; $display("FAIL b2b_first got %h want %h", {outs, frame_count}, {Exp60, 16'd5});
    end
    pulse_start();
    send_bytes(8'h01, 0, 9);
    pulse_end();
    n_vec++;
    if (outs !== Exp60) begin
      n_err++; $display("FAIL b2b_atomic got %h want %h", outs, Exp60);
    end
    cyc();
    n_vec++;
    if ({outs, frame_count} !== {Exp01, 16'd6}) begin
      n_err++; $display("FAIL b2b_second got %h want %h", {outs, frame_count}, {Exp01, 16'd6});
    end
  endtask

  task automatic test_reset_mid_frame();
    pulse_start();
    send_bytes(8'h77, 0, 5);
    nRESET = 1'b0;
    cyc();
    nRESET = 1'b1;
    n_vec++;
    if ({outs, stat} !== 94'd0) begin
      n_err++; $display("FAIL rst_mid_clear got %h want 0", {outs, stat});
    end
    send_bytes(8'h77, 6, 9);
    pulse_end();
    cyc();
    n_vec++;
    if ({outs, stat} !== 94'd0) begin
      n_err++; $display("FAIL rst_mid_nocommit got %h want 0", {outs, stat});
    end
  endtask

  task automatic test_watchdog();
    nRESET = 1'b0;
    cyc();
    nRESET = 1'b1;
    repeat (100) cyc();
    n_vec++;
    if (wd_tripped_w !== 1'b0) begin
      n_err++; $display("FAIL wd_early got %b want 0", wd_tripped_w);
    end
    cyc();
    n_vec++;
    if ({wd_tripped_w, outs_w} !== {1'b1, 75'd0}) begin
      n_err++; $display("FAIL wd_trip got %h want %h", {wd_tripped_w, outs_w}, {1'b1, 75'd0});
    end
    pulse_start();
    send_bytes(8'h01, 0, 9);
    pulse_end();
    cyc();
    n_vec++;
    if ({wd_tripped_w, outs_w} !== {1'b0, Exp01}) begin
      n_err++; $display("FAIL wd_recover got %h want %h", {wd_tripped_w, outs_w}, {1'b0, Exp01});
    end
    repeat (100) cyc();
    n_vec++;
    if ({wd_tripped_w, outs_w} !== {1'b0, Exp01}) begin
      n_err++; $display("FAIL wd_rearm got %h want %h", {wd_tripped_w, outs_w}, {1'b0, Exp01});
    end
    cyc();
    n_vec++;
    if ({wd_tripped_w, outs_w} !== {1'b1, ExpTrip01}) begin
      n_err++;
      $display("FAIL wd_retrip got %h want %h", {wd_tripped_w, outs_w}, {1'b1, ExpTrip01});
    end
    n_vec++;
    if (wd_tripped !== 1'b0) begin
      n_err++; $display("FAIL wd_default_inst got %b want 0", wd_tripped);
    end
  endtask

  // Commit lands on exactly the cycle the 100-cycle counter reaches its limit
  task automatic test_commit_vs_trip();
    nRESET = 1'b0;
    cyc();
    nRESET = 1'b1;
    repeat (88) cyc();
    pulse_start();
    send_bytes(8'h30, 0, 9);
    pulse_end();
    n_vec++;
    if (wd_tripped_w !== 1'b0) begin
      n_err++; $display("FAIL cvt_pre got %b want 0", wd_tripped_w);
    end
    cyc();
    n_vec++;
    if ({wd_tripped_w, outs_w} !== {1'b0, Exp30}) begin
      n_err++; $display("FAIL cvt_commit got %h want %h", {wd_tripped_w, outs_w}, {1'b0, Exp30});
    end
  endtask

  initial begin
    nRESET      = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    byte_valid  = 1'b0;
    byte_index  = '0;
    byte_data   = '0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_short_frame();
    test_out_of_range();
    test_same_cycle_end();
    test_double_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_watchdog();
    test_commit_vs_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
